// File: rtl/debug_scan_master.sv
// rtl/debug_scan_master.sv - virtual-JTAG scan initiator for the 2-bit-IR debug slave port
// Optional: define DEBUG_SCAN_IR_CAPTURE_EN to capture vs_ir_out into rsp_ir during UIR.
module debug_scan_master #(
  parameter int DR_W = 38,
  parameter int HALF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [1:0]      rsp_ir,
  output logic            vs_tck,
  output logic            vs_tdi,
  input  logic            vs_tdo,
  output logic [1:0]      vs_ir_in,
  input  logic [1:0]      vs_ir_out,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            vs_rti
);

  localparam int PER = 2 * HALF;
  localparam int PW  = $clog2(PER);
  localparam int BW  = $clog2(DR_W + 1);
  localparam logic [PW-1:0] PH_RISE = PW'(HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(PER - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DR_W-1:0] shift_q, shift_d;
  logic [1:0]      ir_q, ir_d;
  logic            tdo_q, tdo_d;

  logic scanning, rise, last, tdo_bit;

  assign scanning = (state_q == S_UIR) || (state_q == S_CDR) ||
                    (state_q == S_SDR) || (state_q == S_UDR);
  assign rise     = scanning && (phase_q == PH_RISE);
  assign last     = scanning && (phase_q == PH_LAST);
  // With HALF=1 the rising cycle is also the period end, so take tdo straight from the pin.
  assign tdo_bit  = rise ? vs_tdo : tdo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ir_q    <= 2'b00;
      tdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ir_q    <= ir_d;
      tdo_q   <= tdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ir_d    = ir_q;
    tdo_d   = tdo_q;
    if (rise) tdo_d = vs_tdo;
    if (scanning) phase_d = last ? '0 : phase_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          shift_d = cmd_dr;
          bit_d   = '0;
          state_d = S_UIR;
        end
      end
      S_UIR: if (last) state_d = S_CDR;
      S_CDR: if (last) state_d = S_SDR;
      S_SDR: begin
        if (last) begin
          shift_d = {tdo_bit, shift_q[DR_W-1:1]};
          if (bit_q == BIT_LAST) state_d = S_UDR;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      S_UDR:  if (last) state_d = S_DONE;
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    vs_rti    = (state_q == S_IDLE) || (state_q == S_DONE);
    vs_uir    = (state_q == S_UIR);
    vs_cdr    = (state_q == S_CDR);
    vs_sdr    = (state_q == S_SDR);
    vs_udr    = (state_q == S_UDR);
    vs_tck    = scanning && (phase_q >= PH_RISE);
    vs_tdi    = (state_q == S_SDR) && shift_q[0];
    vs_ir_in  = ir_q;
    rsp_dr    = shift_q;
  end

`ifdef DEBUG_SCAN_IR_CAPTURE_EN
  logic [1:0] ir_cap_q;

  always_ff @(posedge clk) begin
    if (reset) ir_cap_q <= 2'b00;
    else if ((state_q == S_UIR) && rise) ir_cap_q <= vs_ir_out;
  end

  assign rsp_ir = ir_cap_q;
`else
  logic unused_ir_out;

  assign unused_ir_out = ^vs_ir_out;
  assign rsp_ir = 2'b00;
`endif

endmodule

// File: tb/tb_debug_scan_master.sv
// tb/tb_debug_scan_master.sv - directed self-checking bench for debug_scan_master
module tb_debug_scan_master;

  localparam int DR_W = 38;
  localparam int HALF = 2;
  localparam logic [DR_W-1:0] DR1  = 38'h2A_5A5A_5A5A;
  localparam logic [DR_W-1:0] EXP1 = 38'h14_B4B4_B4B4;
  localparam logic [DR_W-1:0] DR2  = 38'h3F_0000_0001;
  localparam logic [DR_W-1:0] EXP2 = 38'h3E_0000_0002;
`ifdef DEBUG_SCAN_IR_CAPTURE_EN
  localparam logic [1:0] EXP_IR1 = 2'b11;
  localparam logic [1:0] EXP_IR2 = 2'b10;
`else
  localparam logic [1:0] EXP_IR1 = 2'b00;
  localparam logic [1:0] EXP_IR2 = 2'b00;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_ir = 2'b00;
  logic [DR_W-1:0] cmd_dr = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [DR_W-1:0] rsp_dr;
  logic [1:0] rsp_ir;
  logic vs_tck, vs_tdi, vs_tdo;
  logic [1:0] vs_ir_in;
  logic [1:0] vs_ir_out = 2'b00;
  logic vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_scan_master #(.DR_W(DR_W), .HALF(HALF)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
    .vs_tck(vs_tck), .vs_tdi(vs_tdi), .vs_tdo(vs_tdo),
    .vs_ir_in(vs_ir_in), .vs_ir_out(vs_ir_out),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_rti(vs_rti)
  );

  // Target DR cell: capture 0 in CDR, sample tdi on tck rise, present it on tdo at tck fall.
  logic tgt_d = 1'b0;
  logic tgt_tdo = 1'b0;
  assign vs_tdo = tgt_tdo;
  always @(posedge vs_tck) begin
    if (vs_cdr) tgt_d <= 1'b0;
    else if (vs_sdr) tgt_d <= vs_tdi;
  end
  always @(negedge vs_tck) tgt_tdo <= tgt_d;

  logic mon_en = 1'b0;
  logic tck_prev = 1'b0;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rise = 0, n_multi = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (vs_uir) n_uir++;
      if (vs_cdr) n_cdr++;
      if (vs_sdr) n_sdr++;
      if (vs_udr) n_udr++;
      if (vs_sdr && vs_tck && !tck_prev) n_rise++;
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti}) != 1) n_multi++;
    end
    tck_prev = vs_tck;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [1:0] ir, input logic [DR_W-1:0] dr, output int lat);
    @(negedge clk);
    check_eq("cmd_ready_before_scan", cmd_ready, 1);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    check_eq("uir_first_cycle", vs_uir, 1);
    check_eq("ir_in_value", vs_ir_in, ir);
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rti", vs_rti, 1);
    check_eq("rst_tck", vs_tck, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_dr", rsp_dr, 0);
    check_eq("rst_rsp_ir", rsp_ir, 0);
    check_eq("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
    check_eq("rst_tdi_ir_in", {vs_tdi, vs_ir_in}, 0);

    vs_ir_out = 2'b11;
    mon_en = 1'b1;
    run_scan(2'b01, DR1, lat);
    mon_en = 1'b0;
    vs_ir_out = 2'b00;
    check_eq("scan1_latency", lat, 165);
    check_eq("scan1_rsp_dr", rsp_dr, EXP1);
    check_eq("scan1_rsp_ir", rsp_ir, EXP_IR1);
    check_eq("uir_cycles", n_uir, 4);
    check_eq("cdr_cycles", n_cdr, 4);
    check_eq("sdr_cycles", n_sdr, 152);
    check_eq("udr_cycles", n_udr, 4);
    check_eq("sdr_tck_rises", n_rise, 38);
    check_eq("strobe_overlap", n_multi, 0);

    cmd_ir = 2'b11;
    cmd_dr = 38'h00_0000_00FF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_rsp_dr", rsp_dr, EXP1);
      check_eq("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_hs_rsp_valid", rsp_valid, 0);
    check_eq("post_hs_cmd_ready", cmd_ready, 1);
    check_eq("post_hs_no_uir", vs_uir, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("next_cmd_uir", vs_uir, 1);
    check_eq("next_cmd_ir_in", vs_ir_in, 2'b11);

    w = 0;
    while (!vs_sdr && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("sdr_reached", vs_sdr, 1);
    repeat (4 * HALF * 10 / 2) @(negedge clk);
    check_eq("sdr_bit10", vs_sdr, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    check_eq("midrst_rti", vs_rti, 1);
    check_eq("midrst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
    check_eq("midrst_tck", vs_tck, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;

    vs_ir_out = 2'b10;
    run_scan(2'b10, DR2, lat);
    check_eq("scan2_latency", lat, 165);
    check_eq("scan2_rsp_dr", rsp_dr, EXP2);
    check_eq("scan2_rsp_ir", rsp_ir, EXP_IR2);
    check_eq("scan2_ir_in", vs_ir_in, 2'b10);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("scan2_done_rsp_valid", rsp_valid, 0);
    check_eq("scan2_done_cmd_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
- Host-side initiator for the 2-bit-IR virtual-JTAG debug port of the Nios II debug slave.
- Takes one scan command (IR + 38-bit DR) on a valid/ready interface.
- Drives the virtual-JTAG strobes (tck, tdi, ir_in, uir, cdr, sdr, udr, rti) that the debug slave's TCK/SYSCLK halves consume.
- Shifts the DR through the target and returns the captured tdo stream; used for simulation and for on-chip self-test of the debug path.

Parameters:
- DR_W, 38: data-register scan length in bits.
- HALF, 2: tck half-period in clk cycles (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  scan command present.
- cmd_ready  out  1  master idle, accepting a command.
- cmd_ir  in  2  IR value for this scan.
- cmd_dr  in  DR_W  DR value shifted in, LSB first.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  host consumes result.
- rsp_dr  out  DR_W  tdo bits captured, first bit in [0].
- rsp_ir  out  2  vs_ir_out sampled during UIR (optional feature).
- vs_tck  out  1  generated test clock.
- vs_tdi  out  1  serial data to target.
- vs_tdo  in  1  serial data from target.
- vs_ir_in  out  2  IR presented to target.
- vs_ir_out  in  2  target IR status.
- vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti  out  1 each  virtual JTAG state strobes.

Behaviour:
- Reset value of every output is 0, except cmd_ready = 1 and vs_rti = 1.
- One period = 2*HALF clk cycles:
  - vs_tck = 0 for the first HALF cycles, 1 for the last HALF.
  - Strobes, vs_tdi and vs_ir_in change only on the first cycle of a period.
  - vs_tdo is sampled on the clk cycle where vs_tck goes 0→1.
- FSM:
  - IDLE: rti=1, cmd_ready=1, tck held 0.
    - cmd_valid & cmd_ready latches cmd_ir/cmd_dr → UIR.
  - UIR: 1 period, uir=1, ir_in=cmd_ir; ir_in holds this value until the next command.
  - CDR: 1 period, cdr=1.
  - SDR: DR_W periods, sdr=1.
    - tdi = shift_reg[0]; shift right at each period end.
    - Captured tdo is inserted at [DR_W-1], so after DR_W periods the first tdo bit lands in rsp_dr[0].
  - UDR: 1 period, udr=1.
  - DONE: tck 0, rti=1, rsp_valid=1 holding rsp_dr stable until rsp_ready.
    - Handshake then → IDLE; cmd_ready returns the following cycle.
- Exactly one of uir/cdr/sdr/udr/rti is high at any cycle.
- Latency: command accepted at cycle t → first UIR cycle at t+1 → rsp_valid at t+1+(DR_W+3)*2*HALF. Defaults give t+165.
- Period counter width is clog2(2*HALF); bit counter width is clog2(DR_W+1).
- rsp_ready while in DONE and cmd_valid in the same cycle: the response is consumed and the command is not accepted (cmd_ready is 0 in DONE).
- rsp_ready outside DONE is ignored. cmd_valid outside IDLE is ignored, and the command is not latched.
- Reset mid-scan: on the next cycle, FSM → IDLE, tck=0, all strobes 0 except rti, rsp_valid=0. The partial result is discarded.
- HALF=1: tck toggles every clk; sampling is still on the rising transition.

Optional Feature:
- DEBUG_SCAN_IR_CAPTURE_EN defined: vs_ir_out is sampled at the tck rising edge of the UIR period and held in rsp_ir until the next UIR.
- Undefined: rsp_ir is tied to 2'b00 and the capture register is absent.

Test Plan:
- Reset held 3 cycles, then released → cmd_ready=1, vs_rti=1, vs_tck=0, rsp_valid=0, all other outputs 0.
- cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A, target tdo loopback = tdi delayed one tck → rsp_valid at t+165, rsp_dr = cmd_dr<<1 with bit0 = target reset value 0.
- Monitor strobes during a default scan → uir 4 cycles, cdr 4, sdr 152, udr 4; 38 tck rising edges while sdr=1; never two strobes high together.
- rsp_ready held low 20 cycles in DONE → rsp_valid and rsp_dr stable; new cmd_valid not accepted until one cycle after the handshake.
- reset asserted at SDR bit 10 → next cycle IDLE, rsp_valid=0; a following scan with cmd_ir=2'b10 completes normally.
- With DEBUG_SCAN_IR_CAPTURE_EN, vs_ir_out=2'b11 during UIR → rsp_ir=2'b11; without the macro → rsp_ir=2'b00.
